// File: rtl/vacc_pkg.sv
// Shared definitions for the vector-accumulator stream reader.
//   vacc_reader_state_t : read-side FSM states
//   vacc_last_addr()    : highest channel index of a frame
//   HDR_FRAME_LSB / vacc_hdr_drop_lsb() : field positions inside the
//                         optional sequence-header beat
package vacc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2
  } vacc_reader_state_t;

  localparam int HDR_FRAME_LSB = 0;

  function automatic int vacc_last_addr(input int vector_width);
    return (1 << vector_width) - 1;
  endfunction

  function automatic int vacc_hdr_drop_lsb(input int cnt_width);
    return HDR_FRAME_LSB + cnt_width;
  endfunction

endpackage

// File: rtl/vacc_pingpong_ram.sv
// Two-bank simple dual-port RAM backing the stream reader.
// The bank select is the MSB of both addresses, so each bank is
// 2**(ADDR_WIDTH-1) words deep. Read data is registered (1-cycle latency)
// and only updates when rd_en is high.
// Ports:
//   clk              : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr    : read request
//   rd_data          : registered read data
module vacc_pingpong_ram
  import vacc_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Memory and its output register stay in one plain block so that
  // synthesis maps them onto a block RAM; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vacc_stream_reader.sv
// Consumer end of the vector-accumulator drain interface.
// Drained words are captured into one bank of a ping-pong RAM; when the
// last channel of a frame is written the bank is handed to the reader,
// which streams it as one AXI-Stream packet. Frames completing while the
// reader is still busy are dropped and counted.
// Ports:
//   clk, rst (sync, active-high)
//   ce, wr_data, wr_we, wr_addr : drain write side (ce gates writes only)
//   m_tdata/m_tvalid/m_tready/m_tlast : AXI-Stream master
//   frame_count : packets fully streamed (wraps)
//   drop_count  : frames discarded because the reader was busy (saturates)
//   busy        : reader owns a bank
// Build option:
//   VACC_SEQ_HEADER_EN : prefix every packet with a header beat holding
//                        {drop_count, frame_count} sampled at handoff.
module vacc_stream_reader
  import vacc_pkg::*;
#(
  parameter int VECTOR_WIDTH = 11,
  parameter int DATA_WIDTH   = 128,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_we,
  input  logic [VECTOR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic                    busy
);

`ifdef VACC_SEQ_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam logic [VECTOR_WIDTH-1:0] LAST_ADDR = VECTOR_WIDTH'(vacc_last_addr(VECTOR_WIDTH));

  vacc_reader_state_t state_q, state_d;
  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  logic [VECTOR_WIDTH:0] rd_cnt_q, rd_cnt_d;
  logic ram_vld_q, ram_vld_d;
  logic ram_last_q, ram_last_d;
  logic hdr_pend_q, hdr_pend_d;
  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic [1:0] buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] buf0_data_q, buf0_data_d, buf1_data_q, buf1_data_d;
  logic buf0_last_q, buf0_last_d, buf1_last_q, buf1_last_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic wr_en, complete, pop, final_beat, handoff, rd_issue, rd_bank_sel;
  logic push, push_last;
  logic [VECTOR_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] ram_rdata, push_data;
  logic [2:0] occupancy;

  always_comb begin
    wr_en      = ce && wr_we;
    complete   = wr_en && (wr_addr == LAST_ADDR);
    pop        = (buf_cnt_q != 2'd0) && m_tready;
    final_beat = pop && buf0_last_q;
    handoff    = complete && ((state_q == IDLE) || final_beat);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (handoff) state_d = PREFETCH;
      PREFETCH: state_d = STREAM;
      STREAM:   if (final_beat) state_d = handoff ? PREFETCH : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Read scheduling. Words in flight (RAM output register or pending
  // header) plus buffered words must never exceed the two skid slots.
  // Without a header, word 0 is fetched in the handoff cycle itself so
  // that PREFETCH covers the RAM latency; rd_cnt then points at word 1.
  always_comb begin
    occupancy   = {1'b0, buf_cnt_q} + {2'b00, ram_vld_q} + {2'b00, hdr_pend_q};
    rd_issue    = 1'b0;
    rd_word     = rd_cnt_q[VECTOR_WIDTH-1:0];
    rd_bank_sel = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    hdr_pend_d  = 1'b0;
    if (handoff) begin
      rd_bank_d   = wr_bank_q;
      rd_bank_sel = wr_bank_q;
      if (HDR_EN) begin
        rd_cnt_d   = '0;
        hdr_pend_d = 1'b1;
      end else begin
        rd_issue = 1'b1;
        rd_word  = '0;
        rd_cnt_d = (VECTOR_WIDTH+1)'(1);
      end
    end else if ((state_q != IDLE) && !rd_cnt_q[VECTOR_WIDTH] &&
                 (occupancy < (pop ? 3'd3 : 3'd2))) begin
      rd_issue = 1'b1;
      rd_cnt_d = rd_cnt_q + (VECTOR_WIDTH+1)'(1);
    end
    ram_vld_d  = rd_issue;
    ram_last_d = rd_issue && (rd_word == LAST_ADDR);
  end

`ifdef VACC_SEQ_HEADER_EN
  localparam int DROP_LSB = vacc_hdr_drop_lsb(CNT_WIDTH);

  always_comb begin
    hdr_d = hdr_q;
    if (handoff) begin
      hdr_d = '0;
      hdr_d[HDR_FRAME_LSB +: CNT_WIDTH] = frame_count_q;
      hdr_d[DROP_LSB +: CNT_WIDTH]      = drop_count_q;
    end
  end
`else
  assign hdr_d = '0;
`endif

  // Two-entry skid buffer; entry 0 is the beat presented on the stream.
  always_comb begin
    push        = ram_vld_q || hdr_pend_q;
    push_data   = hdr_pend_q ? hdr_q : ram_rdata;
    push_last   = !hdr_pend_q && ram_last_q;
    buf_cnt_d   = buf_cnt_q;
    buf0_data_d = buf0_data_q;
    buf0_last_d = buf0_last_q;
    buf1_data_d = buf1_data_q;
    buf1_last_d = buf1_last_q;
    unique case ({push, pop})
      2'b01: begin
        buf0_data_d = buf1_data_q;
        buf0_last_d = buf1_last_q;
        buf_cnt_d   = buf_cnt_q - 2'd1;
      end
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_data_d = push_data;
          buf0_last_d = push_last;
        end else begin
          buf1_data_d = push_data;
          buf1_last_d = push_last;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_data_d = push_data;
          buf0_last_d = push_last;
        end else begin
          buf0_data_d = buf1_data_q;
          buf0_last_d = buf1_last_q;
          buf1_data_d = push_data;
          buf1_last_d = push_last;
        end
      end
      default: ;
    endcase
  end

  // A completed frame that cannot be handed over stays in the write bank
  // and is overwritten by the next frame.
  always_comb begin
    wr_bank_d     = handoff ? ~wr_bank_q : wr_bank_q;
    frame_count_d = final_beat ? frame_count_q + CNT_WIDTH'(1) : frame_count_q;
    drop_count_d  = drop_count_q;
    if (complete && !handoff && (drop_count_q != '1))
      drop_count_d = drop_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_cnt_q      <= '0;
      ram_vld_q     <= 1'b0;
      ram_last_q    <= 1'b0;
      hdr_pend_q    <= 1'b0;
      hdr_q         <= '0;
      buf_cnt_q     <= 2'd0;
      buf0_data_q   <= '0;
      buf0_last_q   <= 1'b0;
      buf1_data_q   <= '0;
      buf1_last_q   <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      rd_cnt_q      <= rd_cnt_d;
      ram_vld_q     <= ram_vld_d;
      ram_last_q    <= ram_last_d;
      hdr_pend_q    <= hdr_pend_d;
      hdr_q         <= hdr_d;
      buf_cnt_q     <= buf_cnt_d;
      buf0_data_q   <= buf0_data_d;
      buf0_last_q   <= buf0_last_d;
      buf1_data_q   <= buf1_data_d;
      buf1_last_q   <= buf1_last_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  vacc_pingpong_ram #(
    .ADDR_WIDTH(VECTOR_WIDTH + 1),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr({wr_bank_q, wr_addr}),
    .wr_data(wr_data),
    .rd_en  (rd_issue),
    .rd_addr({rd_bank_sel, rd_word}),
    .rd_data(ram_rdata)
  );

  assign m_tvalid    = (buf_cnt_q != 2'd0);
  assign m_tdata     = buf0_data_q;
  assign m_tlast     = buf0_last_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vacc_stream_reader.sv
// Testbench for vacc_stream_reader (VECTOR_WIDTH=3, default build).
// A directed table covers the single-frame case; further directed
// sequences cover backpressure, drops, back-to-back handoff, ce gating
// and mid-stream reset; a random phase follows. Every cycle the outputs
// are compared against a frame-level reference model.
module tb_vacc_stream_reader;

  localparam int VW    = 3;
  localparam int DW    = 128;
  localparam int CW    = 32;
  localparam int WORDS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [DW-1:0] wr_data;
  logic          wr_we;
  logic [VW-1:0] wr_addr;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] drop_count;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: a packet is a snapshot of the captured bank, visible
  // from two cycles after completion, one beat per ready cycle.
  logic [DW-1:0] mdl_mem [2][WORDS];
  logic [DW-1:0] mdl_pkt [WORDS];
  bit            mdl_own;
  int            mdl_idx;
  int            mdl_start;
  int            mdl_bank;
  int            mdl_cycle = 0;
  logic [CW-1:0] mdl_frames;
  logic [CW-1:0] mdl_drops;

  typedef struct {
    logic          ce;
    logic          we;
    int            addr;
    logic [DW-1:0] data;
    logic          rdy;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_last;
    int            exp_frames;
    logic          exp_busy;
  } row_t;

  row_t tbl [18];

  vacc_stream_reader #(
    .VECTOR_WIDTH(VW),
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .wr_data    (wr_data),
    .wr_we      (wr_we),
    .wr_addr    (wr_addr),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .frame_count(frame_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h want=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, checks the current
  // outputs against the model, advances the model across the rising edge.
  task automatic applyStimulus(input logic c, input logic we, input int addr,
                               input logic [DW-1:0] d, input logic rdy);
    bit vis;
    bit acc;
    ce       = c;
    wr_we    = we;
    wr_addr  = VW'(addr);
    wr_data  = d;
    m_tready = rdy;
    vis = mdl_own && (mdl_cycle >= mdl_start) && (mdl_idx < WORDS);
    checkOutput("m_tvalid", DW'(m_tvalid), DW'(vis));
    if (vis) begin
      checkOutput("m_tdata", m_tdata, mdl_pkt[mdl_idx]);
      checkOutput("m_tlast", DW'(m_tlast), DW'(mdl_idx == WORDS - 1));
    end
    checkOutput("frame_count", DW'(frame_count), DW'(mdl_frames));
    checkOutput("drop_count", DW'(drop_count), DW'(mdl_drops));
    checkOutput("busy", DW'(busy), DW'(mdl_own));
    acc = vis && rdy;
    if (acc) begin
      mdl_idx++;
      if (mdl_idx == WORDS) begin
        mdl_own = 1'b0;
        mdl_frames++;
      end
    end
    if (c && we) begin
      mdl_mem[mdl_bank][addr] = d;
      if (addr == WORDS - 1) begin
        if (!mdl_own) begin
          for (int i = 0; i < WORDS; i++) mdl_pkt[i] = mdl_mem[mdl_bank][i];
          mdl_idx   = 0;
          mdl_start = mdl_cycle + 2;
          mdl_own   = 1'b1;
          mdl_bank  = 1 - mdl_bank;
        end else if (mdl_drops != '1) begin
          mdl_drops++;
        end
      end
    end
    mdl_cycle++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst      = 1'b1;
    ce       = 1'b0;
    wr_we    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    m_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    mdl_own    = 1'b0;
    mdl_idx    = 0;
    mdl_frames = '0;
    mdl_drops  = '0;
    mdl_bank   = 0;
    mdl_cycle++;
  endtask

  task automatic writeFrame(input int base, input logic rdy);
    for (int a = 0; a < WORDS; a++) applyStimulus(1'b1, 1'b1, a, DW'(base + a), rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, '0, rdy);
  endtask

  initial begin
    int lasts;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Single frame, directed table
    for (int i = 0; i < 18; i++) begin
      tbl[i].ce         = (i < 8);
      tbl[i].we         = (i < 8);
      tbl[i].addr       = (i < 8) ? i : 0;
      tbl[i].data       = DW'(100 + i);
      tbl[i].rdy        = 1'b1;
      tbl[i].exp_valid  = (i >= 9) && (i <= 16);
      tbl[i].exp_data   = DW'(100 + i - 9);
      tbl[i].exp_last   = (i == 16);
      tbl[i].exp_frames = (i >= 17) ? 1 : 0;
      tbl[i].exp_busy   = (i >= 8) && (i <= 16);
    end
    doReset();
    checkOutput("reset_tdata", m_tdata, '0);
    checkOutput("reset_tlast", DW'(m_tlast), '0);
    for (int i = 0; i < 18; i++) begin
      checkOutput("tbl_valid", DW'(m_tvalid), DW'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        checkOutput("tbl_data", m_tdata, tbl[i].exp_data);
        checkOutput("tbl_last", DW'(m_tlast), DW'(tbl[i].exp_last));
      end
      checkOutput("tbl_frames", DW'(frame_count), DW'(tbl[i].exp_frames));
      checkOutput("tbl_busy", DW'(busy), DW'(tbl[i].exp_busy));
      applyStimulus(tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].rdy);
    end

    // Backpressure with ready pattern 1,0,0,1
    doReset();
    lasts = 0;
    for (int i = 0; i < 48; i++) begin
      if (m_tvalid && m_tlast && pat[i % 4]) lasts++;
      if (i < WORDS) applyStimulus(1'b1, 1'b1, i, DW'(100 + i), pat[i % 4]);
      else applyStimulus(1'b0, 1'b0, 0, '0, pat[i % 4]);
    end
    checkOutput("bp_tlast_count", DW'(lasts), DW'(1));
    checkOutput("bp_frames", DW'(frame_count), DW'(1));

    // Drop: second frame completes while the first is stalled
    doReset();
    writeFrame(100, 1'b0);
    writeFrame(200, 1'b0);
    idle(2, 1'b0);
    checkOutput("drop_drops", DW'(drop_count), DW'(1));
    checkOutput("drop_frames", DW'(frame_count), DW'(0));
    idle(15, 1'b1);
    checkOutput("drop_frames_after", DW'(frame_count), DW'(1));

    // Frame B completes on the same cycle as A's tlast handshake
    doReset();
    writeFrame(100, 1'b1);
    for (int a = 0; a < WORDS - 1; a++) applyStimulus(1'b1, 1'b1, a, DW'(200 + a), 1'b1);
    idle(1, 1'b1);
    checkOutput("simul_last_pending", DW'(m_tvalid && m_tlast), DW'(1));
    applyStimulus(1'b1, 1'b1, WORDS - 1, DW'(207), 1'b1);
    idle(12, 1'b1);
    checkOutput("simul_drops", DW'(drop_count), DW'(0));
    checkOutput("simul_frames", DW'(frame_count), DW'(2));

    // ce gating: writes with ce=0 must be ignored
    doReset();
    for (int a = 0; a < WORDS - 1; a++) begin
      applyStimulus(1'b1, 1'b1, a, DW'(100 + a), 1'b1);
      applyStimulus(1'b0, 1'b1, a, DW'(900 + a), 1'b1);
    end
    applyStimulus(1'b0, 1'b1, WORDS - 1, DW'(907), 1'b1);
    idle(3, 1'b1);
    checkOutput("ce_no_completion", DW'(busy), DW'(0));
    applyStimulus(1'b1, 1'b1, WORDS - 1, DW'(107), 1'b1);
    idle(12, 1'b1);
    checkOutput("ce_frames", DW'(frame_count), DW'(1));

    // Reset after beat 3 has been accepted
    doReset();
    writeFrame(100, 1'b1);
    idle(5, 1'b1);
    doReset();
    checkOutput("rst_tvalid", DW'(m_tvalid), DW'(0));
    checkOutput("rst_frames", DW'(frame_count), DW'(0));
    checkOutput("rst_drops", DW'(drop_count), DW'(0));
    checkOutput("rst_busy", DW'(busy), DW'(0));
    writeFrame(300, 1'b1);
    idle(12, 1'b1);
    checkOutput("rst_frames_after", DW'(frame_count), DW'(1));

    // Random traffic against the model
    doReset();
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, WORDS - 1)),
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 3) != 0);
    end
    idle(24, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vacc_stream_reader.md
Name: vacc_stream_reader

Overview:
- Consumer end of the vector-accumulator drain interface.
- Captures each drained spectrum (one word per channel, written with we/addr/data) into a ping-pong buffer.
- Once a full vector is captured, streams it out as one AXI-Stream packet toward the packetiser/DMA.
- Decouples the accumulator's fixed-rate drain from downstream backpressure, and counts dropped frames.

Parameters:
- VECTOR_WIDTH, 11: log2 of channels per vector; frame = 2**VECTOR_WIDTH words.
- DATA_WIDTH, 128: width of drain data and stream data.
- CNT_WIDTH, 32: width of frame_count and drop_count.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- ce  input  1  clock enable; gates the write (capture) side only
- wr_data  input  DATA_WIDTH  drained accumulator word
- wr_we  input  1  write strobe for wr_data
- wr_addr  input  VECTOR_WIDTH  channel index of wr_data
- m_tdata  output  DATA_WIDTH  stream data
- m_tvalid  output  1  stream valid
- m_tready  input  1  stream ready
- m_tlast  output  1  last beat of packet
- frame_count  output  CNT_WIDTH  frames fully streamed (increments on tlast handshake)
- drop_count  output  CNT_WIDTH  completed frames discarded due to busy reader
- busy  output  1  high while the reader owns a bank (state != IDLE)

Behaviour:
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, frame_count=0, drop_count=0, busy=0, wr_bank=0, read FSM=IDLE.
- Storage: two banks, each 2**VECTOR_WIDTH x DATA_WIDTH. Write port and read port are independent; read latency 1 cycle.
- Write side:
  - When ce && wr_we: mem[wr_bank][wr_addr] <= wr_data.
  - Addresses may arrive in any order or with gaps; unwritten words hold stale data.
- Frame completion: ce && wr_we && wr_addr == 2**VECTOR_WIDTH-1. That write itself is stored first. Then:
  - If reader is IDLE, or is accepting its final beat (m_tvalid && m_tready && m_tlast) in the same cycle: hand wr_bank to the reader and toggle wr_bank.
  - Otherwise: drop the frame; drop_count += 1 (saturating at all-ones); wr_bank unchanged, so the next frame overwrites it.
- Read FSM states:
  - IDLE: no bank owned. On handoff, latch rd_bank and set rd_addr=0, then go to PREFETCH.
  - PREFETCH: one cycle for the first BRAM read to return, then go to STREAM.
  - STREAM: presents words 0..2**VECTOR_WIDTH-1 in order.
    - m_tlast=1 only on word 2**VECTOR_WIDTH-1.
    - On the tlast handshake: frame_count += 1 (wraps). Go to IDLE, or directly to PREFETCH if a new handoff occurs in the same cycle.
- Stream timing:
  - First m_tvalid is asserted 2 cycles after the completion cycle.
  - With m_tready held high, one beat per cycle, no bubbles.
  - AXI rules hold: m_tdata, m_tlast and m_tvalid stay stable while m_tvalid && !m_tready, and m_tvalid never drops without a handshake.
  - A 2-entry skid/output register absorbs the 1-cycle read latency.
- ce does not gate the read side or the counters.
- Reset mid-stream: m_tvalid=0 on the next cycle. The partial packet is abandoned with no tlast, and memory contents are don't-care.

Optional Feature:
- VACC_SEQ_HEADER_EN defined: each packet is prefixed with one header beat.
  - Header m_tdata = {zeros, drop_count, frame_count} (low 2*CNT_WIDTH bits, sampled at handoff), with m_tlast=0.
  - Packet length becomes 2**VECTOR_WIDTH+1 beats; first m_tvalid timing is unchanged (the header is the first beat).
- Undefined: packets are exactly 2**VECTOR_WIDTH data beats.

Decomposition:
- Package vacc_pkg holds:
  - enum vacc_reader_state_t {IDLE, PREFETCH, STREAM} (2 bits);
  - localparam function for the last-address constant;
  - header-field offsets.
- Sub-module vacc_pingpong_ram: simple dual-port, 2 banks, bank select bit prepended to the address, registered read. Keeps BRAM inference isolated.

Test Plan (VECTOR_WIDTH=3, DATA_WIDTH=128, CNT_WIDTH=32):
- Single frame, m_tready=1: write addrs 0..7 with data 100+addr (ce=1) -> m_tvalid 2 cycles after addr 7; data 100..107 on consecutive cycles; m_tlast on 107; frame_count=1; drop_count=0.
- Backpressure: same frame with m_tready toggling 1,0,0,1,... -> every beat held stable while stalled; sequence 100..107 intact; exactly one tlast.
- Drop: hold m_tready=0, complete frame A then frame B -> drop_count=1, frame_count=0. Then m_tready=1 -> only A's data is streamed; frame_count=1.
- Simultaneous: frame B completion in the same cycle as A's tlast handshake -> no drop; B streams next with words 200..207; frame_count ends at 2.
- ce gating: write strobes with ce=0 interleaved with a valid frame -> ignored; no completion from a ce=0 write to addr 7.
- Reset mid-stream: assert rst after beat 3 -> m_tvalid=0 next cycle, counters 0. A subsequent full frame streams correctly from word 0.
